multi_cycle_control_unit: RTL and testbench

Multi-cycle RV32I control unit: a state machine that sequences FETCH, DECODE, EXECUTE, MEM and WB for every RV32I base opcode class. It drives register-file, instruction-register, PC, ALU and data-bus controls for the multi-cycle datapath. It handshakes with data memory through a ready signal, so loads and stores tolerate variable memory latency. It replaces the single-cycle R-type-only decoder in the CPU core.

---
 rtl/rv32i_pkg.sv | 52 +++++
 rtl/instr_decoder.sv | 53 +++++
 rtl/multi_cycle_control_unit.sv | 131 +++++++++++++
 tb/tb_multi_cycle_control_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rv32i_pkg
// Shared RV32I definitions for the multi-cycle control path: base opcodes,
// ALU operation codes, the control FSM state enum, the register-file
// write-data source enum and the decoded instruction class.
package rv32i_pkg;

   localparam int ALU_CTRL_W_DEF = 4;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_L     = 7'b0000011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   // {instr[30], funct3}
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b1101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;

   typedef enum logic [2:0] {
      ST_FETCH   = 3'd0,
      ST_DECODE  = 3'd1,
      ST_EXECUTE = 3'd2,
      ST_MEM     = 3'd3,
      ST_WB      = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      WD_ALU    = 3'd0,
      WD_DMEM   = 3'd1,
      WD_IMM    = 3'd2,
      WD_PC_IMM = 3'd3,
      WD_PC_4   = 3'd4
   } rf_wd_src_t;

   typedef enum logic [3:0] {
      CLS_R, CLS_I, CLS_L, CLS_S, CLS_B,
      CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_ILL
   } instr_class_t;

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder
// Combinational RV32I classifier. Maps the instruction word to its opcode
// class, an illegal-opcode flag and the 4-bit ALU operation code.
//   instr_code  in   32  instruction register contents
//   instr_class out      decoded class (CLS_ILL for unknown opcodes)
//   illegal     out  1   opcode not recognised
//   alu_ctrl    out  4   {instr[30], funct3} style ALU code
module instr_decoder
   import rv32i_pkg::*;
(
   input  logic [31:0]  instr_code,
   output instr_class_t instr_class,
   output logic         illegal,
   output logic [3:0]   alu_ctrl
);

   logic [2:0] funct3;
   logic       bit30;
   logic       unused_fields;

   assign funct3 = instr_code[14:12];
   assign bit30  = instr_code[30];
   assign unused_fields = ^{instr_code[31], instr_code[29:15], instr_code[11:7]};

   always_comb begin
      instr_class = CLS_ILL;
      illegal     = 1'b0;
      alu_ctrl    = ALU_ADD;
      case (instr_code[6:0])
         OP_R: begin
            instr_class = CLS_R;
            alu_ctrl    = {bit30, funct3};
         end
         OP_I: begin
            instr_class = CLS_I;
            // instr[30] is part of the immediate except for the right shifts
            alu_ctrl    = (funct3 == 3'b101) ? {bit30, funct3} : {1'b0, funct3};
         end
         OP_B: begin
            instr_class = CLS_B;
            alu_ctrl    = {1'b0, funct3};
         end
         OP_L:     instr_class = CLS_L;
         OP_S:     instr_class = CLS_S;
         OP_LUI:   instr_class = CLS_LUI;
         OP_AUIPC: instr_class = CLS_AUIPC;
         OP_JAL:   instr_class = CLS_JAL;
         OP_JALR:  instr_class = CLS_JALR;
         default:  illegal     = 1'b1;
      endcase
   end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// multi_cycle_control_unit
// Multi-cycle RV32I control FSM. Sequences every base instruction through
// FETCH/DECODE/EXECUTE and, for loads/stores, MEM (and WB for loads).
// Outputs are decoded combinationally from the state and the instruction.
//   clk, reset        core clock, async active-high reset
//   instrCode         IR contents, stable from DECODE onward
//   dMemReady         data memory completed the current request
//   irWe, pcEn, regFileWe, aluSrcMuxSel, aluControl, rfWdSrcMuxSel,
//   branch, jal, jalr, busReq, busWe   datapath controls
//   illegalInstr      pulse in DECODE for an unknown opcode
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_FETCH   | load IR
// ST_DECODE  | classify opcode, flag illegal
// ST_EXECUTE | ALU op; non-memory instructions retire here
// ST_MEM     | data-memory access, held until dMemReady when waiting
// ST_WB      | load result written to register file
module multi_cycle_control_unit
   import rv32i_pkg::*;
#(
   parameter int ALU_CTRL_W  = ALU_CTRL_W_DEF,
   parameter bit MEM_WAIT_EN = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           instrCode,
   input  logic                  dMemReady,
   output logic                  irWe,
   output logic                  pcEn,
   output logic                  regFileWe,
   output logic                  aluSrcMuxSel,
   output logic [ALU_CTRL_W-1:0] aluControl,
   output logic [2:0]            rfWdSrcMuxSel,
   output logic                  branch,
   output logic                  jal,
   output logic                  jalr,
   output logic                  busReq,
   output logic                  busWe,
   output logic                  illegalInstr
);

   state_t       state;
   instr_class_t instr_class;
   logic         dec_illegal;
   logic [3:0]   dec_alu_ctrl;
   logic         mem_done;
   rf_wd_src_t   wd_src;

   instr_decoder u_instr_decoder (
      .instr_code  (instrCode),
      .instr_class (instr_class),
      .illegal     (dec_illegal),
      .alu_ctrl    (dec_alu_ctrl)
   );

   assign mem_done      = !MEM_WAIT_EN || dMemReady;
   assign rfWdSrcMuxSel = wd_src;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_FETCH;
      end else begin
         case (state)
            ST_FETCH:   state <= ST_DECODE;
            ST_DECODE:  state <= ST_EXECUTE;
            ST_EXECUTE: state <= (instr_class == CLS_L || instr_class == CLS_S) ? ST_MEM : ST_FETCH;
            ST_MEM: begin
               if (mem_done) state <= (instr_class == CLS_L) ? ST_WB : ST_FETCH;
            end
            ST_WB:      state <= ST_FETCH;
            default:    state <= ST_FETCH;
         endcase
      end
   end

   // Reset gates every output so nothing leaks out while state is forced.
   always_comb begin
      irWe         = 1'b0;
      pcEn         = 1'b0;
      regFileWe    = 1'b0;
      aluSrcMuxSel = 1'b0;
      aluControl   = '0;
      wd_src       = WD_ALU;
      branch       = 1'b0;
      jal          = 1'b0;
      jalr         = 1'b0;
      busReq       = 1'b0;
      busWe        = 1'b0;
      illegalInstr = 1'b0;
      if (!reset) begin
         case (state)
            ST_FETCH:  irWe = 1'b1;
            ST_DECODE: illegalInstr = dec_illegal;
            ST_EXECUTE: begin
               aluControl = ALU_CTRL_W'(dec_alu_ctrl);
               case (instr_class)
                  CLS_L, CLS_S: aluSrcMuxSel = 1'b1;
                  CLS_ILL:      pcEn = 1'b1;
                  default: begin
                     pcEn         = 1'b1;
                     regFileWe    = (instr_class != CLS_B);
                     aluSrcMuxSel = (instr_class == CLS_I) || (instr_class == CLS_JALR);
                     branch       = (instr_class == CLS_B);
                     jal          = (instr_class == CLS_JAL);
                     jalr         = (instr_class == CLS_JALR);
                     case (instr_class)
                        CLS_LUI:           wd_src = WD_IMM;
                        CLS_AUIPC:         wd_src = WD_PC_IMM;
                        CLS_JAL, CLS_JALR: wd_src = WD_PC_4;
                        default:           wd_src = WD_ALU;
                     endcase
                  end
               endcase
            end
            ST_MEM: begin
               busReq = 1'b1;
               busWe  = (instr_class == CLS_S);
               pcEn   = (instr_class == CLS_S) && mem_done;
            end
            ST_WB: begin
               regFileWe = 1'b1;
               wd_src    = WD_DMEM;
               pcEn      = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
module tb_multi_cycle_control_unit;

   localparam int C_R = 0, C_I = 1, C_L = 2, C_S = 3, C_B = 4,
                  C_LUI = 5, C_AUIPC = 6, C_JAL = 7, C_JALR = 8, C_ILL = 9;

   logic        clk = 1'b0;
   logic        rst_w, rst_nw;
   logic [31:0] instrCode;
   logic        dMemReady;

   logic irWe_w, pcEn_w, regFileWe_w, aluSrcMuxSel_w, branch_w, jal_w, jalr_w, busReq_w, busWe_w, illegalInstr_w;
   logic [3:0] aluControl_w;
   logic [2:0] rfWdSrcMuxSel_w;
   logic irWe_nw, pcEn_nw, regFileWe_nw, aluSrcMuxSel_nw, branch_nw, jal_nw, jalr_nw, busReq_nw, busWe_nw, illegalInstr_nw;
   logic [3:0] aluControl_nw;
   logic [2:0] rfWdSrcMuxSel_nw;

   logic [16:0] act_w, act_nw;
   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   multi_cycle_control_unit #(.ALU_CTRL_W(4), .MEM_WAIT_EN(1'b1)) dut_w (
      .clk(clk), .reset(rst_w), .instrCode(instrCode), .dMemReady(dMemReady),
      .irWe(irWe_w), .pcEn(pcEn_w), .regFileWe(regFileWe_w), .aluSrcMuxSel(aluSrcMuxSel_w),
      .aluControl(aluControl_w), .rfWdSrcMuxSel(rfWdSrcMuxSel_w), .branch(branch_w),
      .jal(jal_w), .jalr(jalr_w), .busReq(busReq_w), .busWe(busWe_w), .illegalInstr(illegalInstr_w)
   );

   multi_cycle_control_unit #(.ALU_CTRL_W(4), .MEM_WAIT_EN(1'b0)) dut_nw (
      .clk(clk), .reset(rst_nw), .instrCode(instrCode), .dMemReady(dMemReady),
      .irWe(irWe_nw), .pcEn(pcEn_nw), .regFileWe(regFileWe_nw), .aluSrcMuxSel(aluSrcMuxSel_nw),
      .aluControl(aluControl_nw), .rfWdSrcMuxSel(rfWdSrcMuxSel_nw), .branch(branch_nw),
      .jal(jal_nw), .jalr(jalr_nw), .busReq(busReq_nw), .busWe(busWe_nw), .illegalInstr(illegalInstr_nw)
   );

   // {irWe, pcEn, regFileWe, aluSrc, aluCtrl[3:0], rfWd[2:0], branch, jal, jalr, busReq, busWe, illegal}
   assign act_w  = {irWe_w, pcEn_w, regFileWe_w, aluSrcMuxSel_w, aluControl_w, rfWdSrcMuxSel_w,
                    branch_w, jal_w, jalr_w, busReq_w, busWe_w, illegalInstr_w};
   assign act_nw = {irWe_nw, pcEn_nw, regFileWe_nw, aluSrcMuxSel_nw, aluControl_nw, rfWdSrcMuxSel_nw,
                    branch_nw, jal_nw, jalr_nw, busReq_nw, busWe_nw, illegalInstr_nw};

   // ---------------- reference model ----------------
   function automatic logic [6:0] opcode_of(int c);
      case (c)
         C_R:     return 7'b0110011;
         C_I:     return 7'b0010011;
         C_L:     return 7'b0000011;
         C_S:     return 7'b0100011;
         C_B:     return 7'b1100011;
         C_LUI:   return 7'b0110111;
         C_AUIPC: return 7'b0010111;
         C_JAL:   return 7'b1101111;
         C_JALR:  return 7'b1100111;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic int cls_of(logic [31:0] ins);
      for (int c = 0; c < C_ILL; c++)
         if (ins[6:0] == opcode_of(c)) return c;
      return C_ILL;
   endfunction

   function automatic logic [3:0] exp_alu(logic [31:0] ins);
      int c = cls_of(ins);
      logic [2:0] f3 = ins[14:12];
      if (c == C_R) return {ins[30], f3};
      if (c == C_I) return (f3 == 3'd5) ? {ins[30], f3} : {1'b0, f3};
      if (c == C_B) return {1'b0, f3};
      return 4'd0;
   endfunction

   function automatic int latency(logic [31:0] ins, int n);
      int c = cls_of(ins);
      if (c == C_S) return 4 + n;
      if (c == C_L) return 5 + n;
      return 3;
   endfunction

   // Expected outputs in cycle k of an instruction that waits n extra MEM cycles.
   function automatic logic [16:0] exp_vec(logic [31:0] ins, int k, int n);
      int c = cls_of(ins);
      logic ir = 0, pc = 0, we = 0, src = 0, br = 0, j = 0, jr = 0, rq = 0, bw = 0, il = 0;
      logic [3:0] alu = 4'd0;
      logic [2:0] wd = 3'd0;
      if (k == 0) ir = 1;
      else if (k == 1) il = (c == C_ILL);
      else if (k == 2) begin
         alu = exp_alu(ins);
         if (c == C_L || c == C_S) src = 1;
         else begin
            pc = 1;
            if (c != C_ILL) begin
               we  = (c != C_B);
               src = (c == C_I || c == C_JALR);
               br  = (c == C_B);
               j   = (c == C_JAL);
               jr  = (c == C_JALR);
               wd  = (c == C_LUI) ? 3'd2 : (c == C_AUIPC) ? 3'd3 :
                     (c == C_JAL || c == C_JALR) ? 3'd4 : 3'd0;
            end
         end
      end else if (k <= 3 + n) begin
         rq = 1;
         bw = (c == C_S);
         pc = (c == C_S) && (k == 3 + n);
      end else begin
         we = 1; wd = 3'd1; pc = 1;
      end
      return {ir, pc, we, src, alu, wd, br, j, jr, rq, bw, il};
   endfunction

   function automatic logic [31:0] rand_instr(int c);
      logic [31:0] r = $urandom;
      logic [6:0]  op = opcode_of(c);
      if (c == C_ILL) begin
         op = r[6:0];
         while (cls_of({25'd0, op}) != C_ILL) op = 7'($urandom);
      end
      return {r[31:7], op};
   endfunction

   // Entered one step after the rising edge that begins FETCH; leaves at the next FETCH.
   task automatic run_instr(input logic [31:0] ins, input int n, input bit use_w, input string name);
      int nn = use_w ? n : 0;
      int lat = latency(ins, nn);
      logic [16:0] act, expv;
      for (int k = 0; k < lat; k++) begin
         if (k == 0) instrCode = ins;
         if (k >= 3) dMemReady = use_w ? (k == 3 + nn) : 1'b0;
         else        dMemReady = 1'($urandom_range(0, 1));
         @(negedge clk);
         act  = use_w ? act_w : act_nw;
         expv = exp_vec(ins, k, nn);
         n_checks++;
         if (act !== expv) begin
            n_fail++;
            $display("FAIL %s ins=%h k=%0d got=%h exp=%h", name, ins, k, act, expv);
         end
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_w = 1'b1; rst_nw = 1'b1; instrCode = 32'h0; dMemReady = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (act_w !== 17'd0) begin n_fail++; $display("FAIL reset_w got=%h exp=0", act_w); end
      n_checks++;
      if (act_nw !== 17'd0) begin n_fail++; $display("FAIL reset_nw got=%h exp=0", act_nw); end
      @(posedge clk); #1;
      rst_w = 1'b0;
   endtask

   task automatic test_alu_ops();
      run_instr({7'b0100000, 5'd3, 5'd2, 3'b000, 5'd1, 7'b0110011}, 0, 1, "sub");
      run_instr({12'h400, 5'd2, 3'b000, 5'd1, 7'b0010011}, 0, 1, "addi_b30");
      run_instr({7'b0100000, 5'd7, 5'd2, 3'b101, 5'd1, 7'b0010011}, 0, 1, "srai");
      run_instr({7'b0000000, 5'd7, 5'd2, 3'b101, 5'd1, 7'b0010011}, 0, 1, "srli");
   endtask

   task automatic test_load_wait();
      run_instr({12'h010, 5'd2, 3'b010, 5'd1, 7'b0000011}, 2, 1, "lw_wait2");
      run_instr({7'h00, 5'd4, 5'd2, 3'b010, 5'h08, 7'b0100011}, 1, 1, "sw_wait1");
      run_instr({12'h020, 5'd2, 3'b010, 5'd1, 7'b0000011}, 0, 1, "lw_wait0");
   endtask

   task automatic test_control_flow();
      run_instr({7'h00, 5'd2, 5'd1, 3'b000, 5'h10, 7'b1100011}, 0, 1, "beq");
      run_instr({20'h12345, 5'd1, 7'b1101111}, 0, 1, "jal");
      run_instr({12'h004, 5'd3, 3'b000, 5'd1, 7'b1100111}, 0, 1, "jalr");
      run_instr({20'hABCDE, 5'd1, 7'b0110111}, 0, 1, "lui");
      run_instr({20'h00042, 5'd1, 7'b0010111}, 0, 1, "auipc");
      run_instr({25'h1ABCDEF, 7'b1111111}, 0, 1, "illegal");
   endtask

   task automatic test_reset_in_mem();
      logic [31:0] ins = {12'h030, 5'd2, 3'b010, 5'd5, 7'b0000011};
      for (int k = 0; k < 4; k++) begin
         if (k == 0) instrCode = ins;
         dMemReady = 1'b0;
         @(negedge clk);
         n_checks++;
         if (act_w !== exp_vec(ins, k, 2)) begin
            n_fail++;
            $display("FAIL rst_mem_pre k=%0d got=%h exp=%h", k, act_w, exp_vec(ins, k, 2));
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (act_w !== exp_vec(ins, 4, 2)) begin
         n_fail++;
         $display("FAIL rst_mem_mem2 got=%h exp=%h", act_w, exp_vec(ins, 4, 2));
      end
      rst_w = 1'b1;
      #1;
      n_checks++;
      if (act_w !== 17'd0) begin n_fail++; $display("FAIL rst_mem_async got=%h exp=0", act_w); end
      dMemReady = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (act_w !== 17'd0) begin n_fail++; $display("FAIL rst_mem_hold got=%h exp=0", act_w); end
      rst_w = 1'b0;
      run_instr({7'h00, 5'd3, 5'd2, 3'b110, 5'd1, 7'b0110011}, 0, 1, "after_rst_mem");
   endtask

   task automatic test_random_wait();
      for (int i = 0; i < 150; i++) begin
         int c = $urandom_range(0, 9);
         run_instr(rand_instr(c), $urandom_range(0, 3), 1, "rand_wait");
      end
   endtask

   task automatic test_store_nowait();
      rst_w = 1'b1; rst_nw = 1'b0;
      #1;
      n_checks++;
      if (act_w !== 17'd0) begin n_fail++; $display("FAIL held_rst_w got=%h exp=0", act_w); end
      run_instr({7'h00, 5'd4, 5'd2, 3'b010, 5'h0C, 7'b0100011}, 0, 0, "sw_nowait");
      run_instr({12'h008, 5'd2, 3'b010, 5'd1, 7'b0000011}, 0, 0, "lw_nowait");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 60; i++) begin
         int c = $urandom_range(0, 9);
         run_instr(rand_instr(c), 0, 0, "b2b_nowait");
      end
   endtask

   initial begin
      test_reset();
      test_alu_ops();
      test_load_wait();
      test_control_flow();
      test_reset_in_mem();
      test_random_wait();
      test_store_nowait();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
